// File: rtl/execute_csr_serial_pkg.sv
// Shared types for the serial CSR execute unit.
// Holds the issue/writeback/feedback/commit pack structs, the CSR op encoding,
// the execute FSM state type and the helper that computes a CSR's new value.
package execute_csr_serial_pkg;

    localparam int CSR_ADDR_WIDTH   = 12;
    localparam int REG_DATA_WIDTH   = 32;
    localparam int ADDR_WIDTH       = 32;
    localparam int PHY_REG_ID_WIDTH = 6;
    localparam int ROB_ID_WIDTH     = 5;
    localparam int EXC_ID_WIDTH     = 5;

    localparam logic [EXC_ID_WIDTH-1:0] EXC_ILLEGAL_INSTRUCTION = 5'd2;

    typedef enum logic [2:0] {
        CSR_RW  = 3'd0,
        CSR_RS  = 3'd1,
        CSR_RC  = 3'd2,
        CSR_RWI = 3'd3,
        CSR_RSI = 3'd4,
        CSR_RCI = 3'd5
    } csr_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        READ = 2'd2,
        PUSH = 2'd3
    } csr_exec_state_t;

    typedef struct packed {
        logic                        enable;
        logic                        valid;
        logic [ADDR_WIDTH-1:0]       pc;
        logic [ROB_ID_WIDTH-1:0]     rob_id;
        logic                        rd_enable;
        logic                        need_rename;
        logic [PHY_REG_ID_WIDTH-1:0] rd_phy;
        logic [REG_DATA_WIDTH-1:0]   src1_value;
        logic [4:0]                  imm;
        logic [CSR_ADDR_WIDTH-1:0]   csr;
        csr_op_t                     op;
        logic                        has_exception;
        logic [EXC_ID_WIDTH-1:0]     exception_id;
        logic [REG_DATA_WIDTH-1:0]   exception_value;
    } issue_execute_pack_t;

    typedef struct packed {
        logic                        enable;
        logic                        valid;
        logic [ADDR_WIDTH-1:0]       pc;
        logic [ROB_ID_WIDTH-1:0]     rob_id;
        logic                        rd_enable;
        logic                        need_rename;
        logic [PHY_REG_ID_WIDTH-1:0] rd_phy;
        logic [REG_DATA_WIDTH-1:0]   rd_value;
        logic [CSR_ADDR_WIDTH-1:0]   csr;
        logic [REG_DATA_WIDTH-1:0]   csr_newvalue;
        logic                        csr_newvalue_valid;
        logic                        has_exception;
        logic [EXC_ID_WIDTH-1:0]     exception_id;
        logic [REG_DATA_WIDTH-1:0]   exception_value;
    } execute_wb_pack_t;

    typedef struct packed {
        logic                        enable;
        logic [PHY_REG_ID_WIDTH-1:0] phy_id;
        logic [REG_DATA_WIDTH-1:0]   value;
    } execute_feedback_channel_t;

    typedef struct packed {
        logic                    enable;
        logic                    next_handle_rob_id_valid;
        logic [ROB_ID_WIDTH-1:0] next_handle_rob_id;
        logic                    flush;
    } commit_feedback_pack_t;

    // Immediate forms use the 5-bit zimm zero-extended in place of src1.
    function automatic logic [REG_DATA_WIDTH-1:0] csr_calc(
        input csr_op_t                   op,
        input logic [REG_DATA_WIDTH-1:0] old_value,
        input logic [REG_DATA_WIDTH-1:0] src1,
        input logic [4:0]                imm
    );
        logic [REG_DATA_WIDTH-1:0] operand;
        operand = (op inside {CSR_RWI, CSR_RSI, CSR_RCI}) ?
                  {{(REG_DATA_WIDTH-5){1'b0}}, imm} : src1;
        case (op)
            CSR_RW, CSR_RWI: csr_calc = operand;
            CSR_RS, CSR_RSI: csr_calc = old_value | operand;
            CSR_RC, CSR_RCI: csr_calc = old_value & ~operand;
            default:         csr_calc = '0;
        endcase
    endfunction

endpackage

// File: rtl/execute_csr_out_queue.sv
// Synchronous FIFO of writeback packs sitting between the CSR execute FSM and
// the WB port.
// Ports: clk, rst (async active-low), flush (clears pointers/count),
//        push/push_data, pop/pop_data (head, combinational), full, empty.
// A push into a full queue is accepted only when the head leaves in the same
// cycle, so occupancy then stays unchanged.
module execute_csr_out_queue
    import execute_csr_serial_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  execute_wb_pack_t push_data,
    input  logic             pop,
    output execute_wb_pack_t pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    execute_wb_pack_t mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        ptr_next = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= push_data;
                wptr      <= ptr_next(wptr);
            end
            if (do_pop) begin
                rptr <= ptr_next(rptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/execute_csr_serial.sv
// Serial CSR execute unit: takes one CSR op at a time from the issue FIFO,
// optionally waits until it is the oldest uncommitted ROB entry, reads the
// CSR file (multi-cycle), computes the new CSR value and queues the result
// for the WB port. rd is forwarded on the execute feedback channel.
// Ports:
//   clk, rst (async active-low)
//   excsr_csrf_addr/excsr_csrf_re, csrf_excsr_data : CSR file read port
//   issue_csr_fifo_data_out/_valid, issue_csr_fifo_pop : issue FIFO head
//   csr_wb_port_data_in/_we/_flush, csr_wb_port_full : WB port
//   csr_execute_channel_feedback_pack : rd bypass
//   commit_feedback_pack : oldest-ROB status and flush request
//   dbg_state : current FSM state
// Handshakes: the issue head is consumed on any edge where pop=1 (pop implies
// valid); the WB port takes data_in on any edge where we=1, and we is never
// raised while full=1. A commit flush overrides both in the same cycle.
module execute_csr_serial
    import execute_csr_serial_pkg::*;
#(
    parameter int WAIT_OLDEST  = 1,
    parameter int READ_LATENCY = 1,
    parameter int OUT_DEPTH    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [CSR_ADDR_WIDTH-1:0] excsr_csrf_addr,
    output logic                      excsr_csrf_re,
    input  logic [REG_DATA_WIDTH-1:0] csrf_excsr_data,
    input  issue_execute_pack_t       issue_csr_fifo_data_out,
    input  logic                      issue_csr_fifo_data_out_valid,
    output logic                      issue_csr_fifo_pop,
    output execute_wb_pack_t          csr_wb_port_data_in,
    output logic                      csr_wb_port_we,
    output logic                      csr_wb_port_flush,
    input  logic                      csr_wb_port_full,
    output execute_feedback_channel_t csr_execute_channel_feedback_pack,
    input  commit_feedback_pack_t     commit_feedback_pack,
    output csr_exec_state_t           dbg_state
);

    localparam logic [1:0] LAT = READ_LATENCY[1:0];

    csr_exec_state_t           state;
    issue_execute_pack_t       op_q;
    logic [REG_DATA_WIDTH-1:0] old_q;
    logic [1:0]                cnt_q;

    logic             flush_req;
    logic             oldest;
    logic             in_read;
    logic             q_push;
    logic             q_full;
    logic             q_empty;
    execute_wb_pack_t q_head;
    execute_wb_pack_t entry;

    assign flush_req = commit_feedback_pack.enable & commit_feedback_pack.flush;
    assign oldest    = commit_feedback_pack.next_handle_rob_id_valid &&
                       (commit_feedback_pack.next_handle_rob_id == op_q.rob_id);
    assign in_read   = (state == READ);

    // Reset gating keeps every output at 0 while rst is low, even those that
    // are combinational from inputs.
    assign issue_csr_fifo_pop = rst & (state == IDLE) & issue_csr_fifo_data_out_valid & ~flush_req;
    assign csr_wb_port_flush  = rst & flush_req;
    assign csr_wb_port_we     = rst & ~q_empty & ~csr_wb_port_full & ~flush_req;
    assign csr_wb_port_data_in = q_head;

    // Strobe covers the READ_LATENCY cycles before the latch cycle; with zero
    // latency the data is combinational, so strobe and latch share a cycle.
    assign excsr_csrf_re   = rst & in_read & ~flush_req & ((LAT == 2'd0) || (cnt_q < LAT));
    assign excsr_csrf_addr = in_read ? op_q.csr : '0;

    assign q_push = (state == PUSH) & ~flush_req & (~q_full | csr_wb_port_we);

    always_comb begin
        entry                    = '0;
        entry.enable             = 1'b1;
        entry.valid              = op_q.valid;
        entry.pc                 = op_q.pc;
        entry.rob_id             = op_q.rob_id;
        entry.rd_enable          = op_q.rd_enable;
        entry.need_rename        = op_q.need_rename;
        entry.rd_phy             = op_q.rd_phy;
        entry.rd_value           = old_q;
        entry.csr                = op_q.csr;
        entry.csr_newvalue       = csr_calc(op_q.op, old_q, op_q.src1_value, op_q.imm);
        entry.csr_newvalue_valid = op_q.valid & ~op_q.has_exception;
        entry.has_exception      = op_q.has_exception;
        entry.exception_id       = op_q.exception_id;
        entry.exception_value    = op_q.exception_value;
    end

    always_comb begin
        csr_execute_channel_feedback_pack        = '0;
        csr_execute_channel_feedback_pack.enable = q_push & op_q.valid & ~op_q.has_exception &
                                                   op_q.rd_enable & op_q.need_rename;
        csr_execute_channel_feedback_pack.phy_id = op_q.rd_phy;
        csr_execute_channel_feedback_pack.value  = old_q;
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            op_q  <= '0;
            old_q <= '0;
            cnt_q <= '0;
        end else if (flush_req) begin
            state <= IDLE;
            cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue_csr_fifo_pop) begin
                        op_q  <= issue_csr_fifo_data_out;
                        old_q <= '0;
                        cnt_q <= '0;
                        if (!issue_csr_fifo_data_out.enable) begin
                            state <= IDLE;
                        end else if (!issue_csr_fifo_data_out.valid ||
                                     issue_csr_fifo_data_out.has_exception) begin
                            state <= PUSH;
                        end else if (WAIT_OLDEST != 0) begin
                            state <= WAIT;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                WAIT: begin
                    if (oldest) begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (cnt_q == LAT) begin
                        old_q <= csrf_excsr_data;
                        state <= PUSH;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                PUSH: begin
                    // Latched data is kept while waiting for queue space.
                    if (q_push) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    execute_csr_out_queue #(
        .DEPTH(OUT_DEPTH)
    ) u_out_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_req),
        .push      (q_push),
        .push_data (entry),
        .pop       (csr_wb_port_we),
        .pop_data  (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

endmodule

// File: tb/tb_execute_csr_serial.sv
module tb_execute_csr_serial;
  import execute_csr_serial_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [CSR_ADDR_WIDTH-1:0] csrf_addr;
  logic                      csrf_re;
  logic [REG_DATA_WIDTH-1:0] csrf_data;
  issue_execute_pack_t       issue;
  logic                      issue_valid;
  logic                      pop;
  execute_wb_pack_t          wb;
  logic                      we;
  logic                      wb_flush;
  logic                      wb_full;
  execute_feedback_channel_t fb;
  commit_feedback_pack_t     commit;
  csr_exec_state_t           st;

  int checks = 0;
  int errors = 0;

  execute_csr_serial #(
    .WAIT_OLDEST  (1),
    .READ_LATENCY (3),
    .OUT_DEPTH    (2)
  ) dut (
    .clk                               (clk),
    .rst                               (rst),
    .excsr_csrf_addr                   (csrf_addr),
    .excsr_csrf_re                     (csrf_re),
    .csrf_excsr_data                   (csrf_data),
    .issue_csr_fifo_data_out           (issue),
    .issue_csr_fifo_data_out_valid     (issue_valid),
    .issue_csr_fifo_pop                (pop),
    .csr_wb_port_data_in               (wb),
    .csr_wb_port_we                    (we),
    .csr_wb_port_flush                 (wb_flush),
    .csr_wb_port_full                  (wb_full),
    .csr_execute_channel_feedback_pack (fb),
    .commit_feedback_pack              (commit),
    .dbg_state                         (st)
  );

  // scoreboard-style comparison
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int rob, input csr_op_t op, input logic [31:0] src1,
                        input logic [4:0] imm, input int phy);
    issue             = '0;
    issue.enable      = 1'b1;
    issue.valid       = 1'b1;
    issue.pc          = 32'h1000 + 32'(rob * 4);
    issue.rob_id      = 5'(rob);
    issue.rd_enable   = 1'b1;
    issue.need_rename = 1'b1;
    issue.rd_phy      = 6'(phy);
    issue.src1_value  = src1;
    issue.imm         = imm;
    issue.csr         = 12'h340;
    issue.op          = op;
  endtask

  // Issue the op already set up, make it oldest, supply CSR data and stop in PUSH.
  task automatic run_to_push(input int rob, input logic [31:0] old_data);
    int n;
    commit.next_handle_rob_id = 5'(rob);
    issue_valid = 1'b1;
    #1;
    n = 0;
    while (!pop && n < 10) begin
      step();
      n++;
    end
    chk("pop_seen", 64'(pop), 64'd1);
    step();
    issue_valid = 1'b0;
    csrf_data = old_data;
    n = 0;
    while (st != PUSH && n < 12) begin
      step();
      n++;
    end
    chk("reach_push", 64'(st), 64'(PUSH));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b0;
    csrf_data = '0;
    wb_full = 1'b0;
    issue = '0;
    issue.enable = 1'b1;
    issue_valid = 1'b1;
    commit = '0;
    commit.enable = 1'b1;
    commit.flush = 1'b1;
    #12;
    chk("rst_pop", 64'(pop), 64'd0);
    chk("rst_flush", 64'(wb_flush), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_re", 64'(csrf_re), 64'd0);
    chk("rst_fb", 64'(fb.enable), 64'd0);
    chk("rst_state", 64'(st), 64'(IDLE));
    chk("rst_wbdata", 64'(wb.rob_id), 64'd0);
    issue_valid = 1'b0;
    commit.flush = 1'b0;
    commit.next_handle_rob_id_valid = 1'b1;
    commit.next_handle_rob_id = 5'd3;
    step();
    rst = 1'b1;
    step();

    // ---------------- 1: exception bypass ----------------
    issue = '0;
    issue.enable = 1'b1;
    issue.valid = 1'b0;
    issue.has_exception = 1'b1;
    issue.exception_id = EXC_ILLEGAL_INSTRUCTION;
    issue.exception_value = 32'hdead;
    issue.rob_id = 5'd4;
    issue.pc = 32'h100;
    issue_valid = 1'b1;
    #1;
    chk("t1_pop", 64'(pop), 64'd1);
    step();
    chk("t1_state_push", 64'(st), 64'(PUSH));
    chk("t1_pop_held", 64'(pop), 64'd0);
    chk("t1_re", 64'(csrf_re), 64'd0);
    chk("t1_fb", 64'(fb.enable), 64'd0);
    chk("t1_we_early", 64'(we), 64'd0);
    issue_valid = 1'b0;
    step();
    chk("t1_we", 64'(we), 64'd1);
    chk("t1_valid", 64'(wb.valid), 64'd0);
    chk("t1_exc", 64'(wb.has_exception), 64'd1);
    chk("t1_exc_id", 64'(wb.exception_id), 64'(EXC_ILLEGAL_INSTRUCTION));
    chk("t1_rob", 64'(wb.rob_id), 64'd4);
    chk("t1_rd_value", 64'(wb.rd_value), 64'd0);
    chk("t1_re2", 64'(csrf_re), 64'd0);
    step();
    chk("t1_drained", 64'(we), 64'd0);

    // ---------------- 2/3: csrrs with wait-oldest and latency 3 ----------------
    set_op(7, CSR_RS, 32'h0000f000, 5'd0, 10);
    commit.next_handle_rob_id = 5'd3;
    issue_valid = 1'b1;
    #1;
    chk("t2_pop", 64'(pop), 64'd1);
    step();
    issue_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_wait_re", 64'(csrf_re), 64'd0);
      chk("t2_wait_state", 64'(st), 64'(WAIT));
      step();
    end
    commit.next_handle_rob_id = 5'd7;
    csrf_data = 32'hdeadbeef;
    step();
    for (int i = 0; i < 3; i++) begin
      csrf_data = 32'h55550000 + 32'(i);
      #1;
      chk("t3_re", 64'(csrf_re), 64'd1);
      chk("t3_addr", 64'(csrf_addr), 64'h340);
      chk("t3_state", 64'(st), 64'(READ));
      step();
    end
    csrf_data = 32'h1ab5dc6e;
    #1;
    chk("t3_re_off", 64'(csrf_re), 64'd0);
    chk("t3_latch_state", 64'(st), 64'(READ));
    step();
    csrf_data = 32'h0;
    chk("t2_push_state", 64'(st), 64'(PUSH));
    chk("t2_fb_en", 64'(fb.enable), 64'd1);
    chk("t2_fb_phy", 64'(fb.phy_id), 64'd10);
    chk("t2_fb_val", 64'(fb.value), 64'h1ab5dc6e);
    step();
    chk("t2_we", 64'(we), 64'd1);
    chk("t2_rd_value", 64'(wb.rd_value), 64'h1ab5dc6e);
    chk("t2_newvalue", 64'(wb.csr_newvalue), 64'h1ab5fc6e);
    chk("t2_nv_valid", 64'(wb.csr_newvalue_valid), 64'd1);
    chk("t2_rob", 64'(wb.rob_id), 64'd7);
    chk("t2_csr", 64'(wb.csr), 64'h340);
    step();

    // ---------------- 4: backpressure, three ops into depth-2 queue ----------------
    wb_full = 1'b1;
    set_op(1, CSR_RWI, 32'hffffffff, 5'd5, 1);
    run_to_push(1, 32'h11);
    chk("t4_fb1", 64'(fb.value), 64'h11);
    step();
    chk("t4_we_blocked", 64'(we), 64'd0);
    set_op(2, CSR_RSI, 32'hffffffff, 5'd3, 2);
    run_to_push(2, 32'h30);
    step();
    set_op(3, CSR_RC, 32'h000000ff, 5'd0, 3);
    run_to_push(3, 32'h1234);
    chk("t4_hold_fb", 64'(fb.enable), 64'd0);
    set_op(4, CSR_RW, 32'h1, 5'd0, 4);
    issue_valid = 1'b1;
    step();
    chk("t4_hold_state", 64'(st), 64'(PUSH));
    chk("t4_no_pop", 64'(pop), 64'd0);
    chk("t4_no_we", 64'(we), 64'd0);
    issue_valid = 1'b0;
    wb_full = 1'b0;
    #1;
    chk("t4_we1", 64'(we), 64'd1);
    chk("t4_rob1", 64'(wb.rob_id), 64'd1);
    chk("t4_nv1", 64'(wb.csr_newvalue), 64'h5);
    chk("t4_old1", 64'(wb.rd_value), 64'h11);
    chk("t4_fb3_en", 64'(fb.enable), 64'd1);
    chk("t4_fb3_val", 64'(fb.value), 64'h1234);
    step();
    chk("t4_we2", 64'(we), 64'd1);
    chk("t4_rob2", 64'(wb.rob_id), 64'd2);
    chk("t4_nv2", 64'(wb.csr_newvalue), 64'h33);
    step();
    chk("t4_we3", 64'(we), 64'd1);
    chk("t4_rob3", 64'(wb.rob_id), 64'd3);
    chk("t4_nv3", 64'(wb.csr_newvalue), 64'h1200);
    chk("t4_old3", 64'(wb.rd_value), 64'h1234);
    step();
    chk("t4_empty", 64'(we), 64'd0);

    // ---------------- 5: commit flush during READ, queue non-empty ----------------
    wb_full = 1'b1;
    set_op(5, CSR_RW, 32'ha5, 5'd0, 5);
    run_to_push(5, 32'h77);
    step();
    set_op(6, CSR_RW, 32'h1, 5'd0, 6);
    commit.next_handle_rob_id = 5'd6;
    issue_valid = 1'b1;
    #1;
    chk("t5_pop", 64'(pop), 64'd1);
    step();
    issue_valid = 1'b0;
    step();
    chk("t5_in_read", 64'(st), 64'(READ));
    chk("t5_re_pre", 64'(csrf_re), 64'd1);
    commit.flush = 1'b1;
    wb_full = 1'b0;
    #1;
    chk("t5_flush", 64'(wb_flush), 64'd1);
    chk("t5_we", 64'(we), 64'd0);
    chk("t5_fb", 64'(fb.enable), 64'd0);
    chk("t5_re", 64'(csrf_re), 64'd0);
    step();
    commit.flush = 1'b0;
    #1;
    chk("t5_idle", 64'(st), 64'(IDLE));
    chk("t5_q_empty", 64'(we), 64'd0);
    chk("t5_flush_off", 64'(wb_flush), 64'd0);
    issue = '0;
    issue.enable = 1'b1;
    issue.rob_id = 5'd8;
    issue_valid = 1'b1;
    #1;
    chk("t5_new_pop", 64'(pop), 64'd1);
    step();
    issue_valid = 1'b0;
    step();
    chk("t5_new_we", 64'(we), 64'd1);
    chk("t5_new_rob", 64'(wb.rob_id), 64'd8);
    chk("t5_new_valid", 64'(wb.valid), 64'd0);
    step();

    // ---------------- 6: async reset mid-WAIT ----------------
    set_op(9, CSR_RW, 32'h1, 5'd0, 9);
    commit.next_handle_rob_id = 5'd3;
    issue_valid = 1'b1;
    step();
    chk("t6_wait", 64'(st), 64'(WAIT));
    rst = 1'b0;
    commit.flush = 1'b1;
    #1;
    chk("t6_state", 64'(st), 64'(IDLE));
    chk("t6_pop", 64'(pop), 64'd0);
    chk("t6_flush", 64'(wb_flush), 64'd0);
    chk("t6_re", 64'(csrf_re), 64'd0);
    chk("t6_we", 64'(we), 64'd0);
    chk("t6_fb", 64'(fb.enable), 64'd0);
    commit.flush = 1'b0;
    issue_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    set_op(10, CSR_RW, 32'h12345678, 5'd0, 7);
    run_to_push(10, 32'hffffffff);
    chk("t6_fb_en", 64'(fb.enable), 64'd1);
    chk("t6_fb_val", 64'(fb.value), 64'hffffffff);
    step();
    chk("t6_we", 64'(we), 64'd1);
    chk("t6_rob", 64'(wb.rob_id), 64'd10);
    chk("t6_nv", 64'(wb.csr_newvalue), 64'h12345678);
    chk("t6_old", 64'(wb.rd_value), 64'hffffffff);
    step();

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
